// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer
// Queued read controller for the datapath bus. Client read requests are
// buffered in a small FIFO. Each request drives one register's Rout select
// for a single cycle. The bus value is captured at the end of that cycle and
// returned on a valid/ready response port.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   req_valid  request offered          req_ready  FIFO not full
//   req_reg    register index 0..15     req_ba     base-address mode read
//   Rout       one-hot register output enable (DRIVE cycle only)
//   BAout      base-address gating strobe (DRIVE cycle only)
//   bus_Data   shared bus value, sampled at the edge ending DRIVE
//   rsp_valid  response held            rsp_ready  consumer accepts
//   rsp_data   captured bus value       rsp_reg    index of the response
//
// Build option: define BUS_READ_SEQ_R0_BYPASS_EN so that base-address reads
// of R0 answer zero directly and skip the bus cycle.
module bus_read_sequencer #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_reg,
   input  logic              req_ba,
   output logic [15:0]       Rout,
   output logic              BAout,
   input  logic [DATA_W-1:0] bus_Data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        rsp_reg
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef BUS_READ_SEQ_R0_BYPASS_EN
   localparam bit R0_BYPASS = 1'b1;
`else
   localparam bit R0_BYPASS = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   state_t          state, state_nx;
   logic [4:0]      fifo_mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            fifo_empty, fifo_full;
   logic            push, pop;
   logic [3:0]      head_reg;
   logic            head_ba, head_bypass;
   logic            cap_bus, cap_zero;
   logic [3:0]      cur_reg;
   logic            cur_ba;

   function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
      reg_onehot = 16'd1 << idx;
   endfunction

   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == FULL_CNT);
   assign req_ready   = ~fifo_full;
   assign push        = req_valid & ~fifo_full;
   assign head_reg    = fifo_mem[rd_ptr][4:1];
   assign head_ba     = fifo_mem[rd_ptr][0];
   assign head_bypass = R0_BYPASS & (head_reg == 4'd0) & head_ba;

   // ---- request FIFO: storage carries no reset, control does
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {req_reg, req_ba};
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---- sequencer FSM
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      cap_bus  = 1'b0;
      cap_zero = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               cap_zero = head_bypass;
               state_nx = head_bypass ? RESP : DRIVE;
            end
         end
         DRIVE: begin
            cap_bus  = 1'b1;
            state_nx = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  cap_zero = head_bypass;
                  state_nx = head_bypass ? RESP : DRIVE;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---- current request (data only, meaningful once popped)
   always_ff @(posedge clk) begin
      if (pop) begin
         cur_reg <= head_reg;
         cur_ba  <= head_ba;
      end
   end

   // ---- response capture
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         rsp_data <= '0;
         rsp_reg  <= '0;
      end else if (cap_bus) begin
         rsp_data <= bus_Data;
         rsp_reg  <= cur_reg;
      end else if (cap_zero) begin
         rsp_data <= '0;
         rsp_reg  <= '0;
      end
   end

   // Bus strobes are decoded from state so reset clears them at once.
   assign Rout      = (state == DRIVE) ? reg_onehot(cur_reg) : 16'd0;
   assign BAout     = (state == DRIVE) & cur_ba;
   assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_bus_read_sequencer.sv
module tb_bus_read_sequencer;

   logic        clk;
   logic        clr;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_reg;
   logic        req_ba;
   logic [15:0] Rout;
   logic        BAout;
   logic [31:0] bus_Data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_reg;

`ifdef BUS_READ_SEQ_R0_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   bus_read_sequencer #(.DEPTH(4), .DATA_W(32)) dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_reg(req_reg), .req_ba(req_ba),
      .Rout(Rout), .BAout(BAout), .bus_Data(bus_Data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_reg(rsp_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register bank on the bus; R0 reads zero when base-address gated.
   logic [31:0] bank [16];
   always_comb begin
      bus_Data = '0;
      for (int i = 0; i < 16; i++)
         if (Rout[i]) bus_Data = bus_Data | ((i == 0 && BAout) ? 32'd0 : bank[i]);
   end

   typedef struct {
      logic [3:0]  r;
      logic        ba;
      logic [31:0] d;
   } req_t;

   req_t drv_q[$];
   req_t exp_q[$];
   int   rsp_cycles[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic        hold_valid = 1'b0;
   logic [31:0] hold_data;
   logic [3:0]  hold_reg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_data(input logic [3:0] r, input logic ba);
      model_data = (r == 4'd0 && ba) ? 32'd0 : bank[r];
   endfunction

   // One clock: sample settled pre-edge values, update the model, step.
   task automatic cycle();
      req_t e;
      #2;
      if (Rout != 16'd0) begin
         chk("rout_onehot", 32'($countones(Rout)), 32'd1);
         while (BYPASS && drv_q.size() > 0 && drv_q[0].r == 4'd0 && drv_q[0].ba)
            void'(drv_q.pop_front());
         if (drv_q.size() == 0) chk("rout_unexpected", 32'(Rout), 32'd0);
         else begin
            e = drv_q.pop_front();
            chk("rout_order", 32'(Rout), 32'(16'd1 << e.r));
            chk("baout_drive", 32'(BAout), 32'(e.ba));
         end
      end else begin
         chk("baout_idle", 32'(BAout), 32'd0);
      end
      if (hold_valid) begin
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_data", rsp_data, hold_data);
         chk("hold_reg", 32'(rsp_reg), 32'(hold_reg));
      end
      hold_valid = rsp_valid && !rsp_ready;
      hold_data  = rsp_data;
      hold_reg   = rsp_reg;
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
         else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_reg", 32'(rsp_reg), 32'(e.r));
            rsp_cycles.push_back(cyc);
         end
      end
      if (req_valid && req_ready) begin
         e.r = req_reg; e.ba = req_ba; e.d = model_data(req_reg, req_ba);
         drv_q.push_back(e);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push_req(input logic [3:0] r, input logic ba);
      logic acc;
      acc = 1'b0;
      req_valid = 1'b1; req_reg = r; req_ba = ba;
      for (int i = 0; i < 40 && !acc; i++) begin
         acc = req_ready;
         cycle();
      end
      chk("push_accept", 32'(acc), 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 60 && (exp_q.size() != 0 || rsp_valid); i++) cycle();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      drv_q.delete();
   endtask

   initial begin
      req_valid = 1'b0; req_reg = '0; req_ba = 1'b0; rsp_ready = 1'b0;
      for (int i = 0; i < 16; i++) bank[i] = $urandom;

      // ---- reset state
      clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rout", 32'(Rout), 32'd0);
      chk("rst_baout", 32'(BAout), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_reg", 32'(rsp_reg), 32'd0);
      clr = 1'b1;
      cycle();

      // ---- single read of R5, then back-pressure
      bank[5] = 32'hDEADBEEF;
      req_valid = 1'b1; req_reg = 4'd5; req_ba = 1'b0;
      cycle();                                   // accept edge E0
      req_valid = 1'b0;
      chk("single_e0_rout", 32'(Rout), 32'd0);
      chk("single_e0_valid", 32'(rsp_valid), 32'd0);
      cycle();                                   // E1: DRIVE begins
      chk("single_drive_rout", 32'(Rout), 32'h0020);
      chk("single_drive_ba", 32'(BAout), 32'd0);
      chk("single_drive_valid", 32'(rsp_valid), 32'd0);
      cycle();                                   // E2: response held
      chk("single_valid", 32'(rsp_valid), 32'd1);
      chk("single_data", rsp_data, 32'hDEADBEEF);
      chk("single_reg", 32'(rsp_reg), 32'd5);
      chk("single_rout_off", 32'(Rout), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rout", 32'(Rout), 32'd0);
         chk("bp_data", rsp_data, 32'hDEADBEEF);
      end
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      chk("single_consumed", 32'(rsp_valid), 32'd0);
      chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

      // ---- R0 base-address read
      bank[0] = 32'h12345678;
      req_valid = 1'b1; req_reg = 4'd0; req_ba = 1'b1;
      cycle();
      req_valid = 1'b0;
      cycle();
      if (BYPASS) begin
         chk("r0_byp_valid", 32'(rsp_valid), 32'd1);
         chk("r0_byp_rout", 32'(Rout), 32'd0);
         chk("r0_byp_ba", 32'(BAout), 32'd0);
         chk("r0_byp_data", rsp_data, 32'd0);
      end else begin
         chk("r0_rout", 32'(Rout), 32'h0001);
         chk("r0_ba", 32'(BAout), 32'd1);
         cycle();
         chk("r0_valid", 32'(rsp_valid), 32'd1);
         chk("r0_data", rsp_data, 32'd0);
      end
      chk("r0_reg", 32'(rsp_reg), 32'd0);
      drain();
      rsp_ready = 1'b0;

      // ---- full FIFO: 1 in RESP, 2..5 queued, 6 refused
      for (int k = 1; k <= 5; k++) begin
         req_valid = 1'b1; req_reg = 4'(k); req_ba = 1'b0;
         chk("full_ready_open", 32'(req_ready), 32'd1);
         cycle();
      end
      req_reg = 4'd6;
      for (int i = 0; i < 3; i++) begin
         chk("full_ready_low", 32'(req_ready), 32'd0);
         chk("full_resp_head", 32'(rsp_reg), 32'd1);
         cycle();
      end
      rsp_ready = 1'b1;
      push_req(4'd6, 1'b0);
      drain();
      rsp_ready = 1'b0;

      // ---- streaming regs 8..15, one response per 2 cycles
      rsp_cycles.delete();
      rsp_ready = 1'b1;
      for (int k = 8; k <= 15; k++) push_req(4'(k), 1'($urandom_range(0, 1)));
      drain();
      chk("stream_count", 32'(rsp_cycles.size()), 32'd8);
      for (int i = 1; i < rsp_cycles.size(); i++)
         chk("stream_spacing", 32'(rsp_cycles[i] - rsp_cycles[i-1]), 32'd2);

      // ---- randomized traffic against the scoreboard
      for (int i = 0; i < 16; i++) bank[i] = $urandom;
      for (int i = 0; i < 400; i++) begin
         req_valid = ($urandom_range(0, 1) == 1);
         req_reg   = 4'($urandom_range(0, 15));
         req_ba    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) req_reg = 4'd0;
         rsp_ready = ($urandom_range(0, 4) < 3);
         cycle();
      end
      drain();
      rsp_ready = 1'b0;

      // ---- reset during DRIVE with three requests queued
      for (int k = 1; k <= 4; k++) push_req(4'(k), 1'b0);
      req_valid = 1'b1; req_reg = 4'd5; req_ba = 1'b0;
      rsp_ready = 1'b1;
      cycle();                                   // response 1 leaves, R2 driven, R5 queued
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("mid_drive_rout", 32'(Rout), 32'h0004);
      clr = 1'b0;
      #1;
      chk("mid_rst_rout", 32'(Rout), 32'd0);
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_data", rsp_data, 32'd0);
      drv_q.delete(); exp_q.delete(); hold_valid = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("post_rst_valid", 32'(rsp_valid), 32'd0);
         chk("post_rst_rout", 32'(Rout), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
